// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam int         FRAME_BITS = 11;

    // Frame word is {stop, parity, D7..D0}; valid when odd parity and stop is high.
    function automatic logic frame_ok(input logic [9:0] f);
        return (^f[8:0]) & f[9];
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Pin-side and code-side signals of the PS/2 receiver, plus FSM state for observation.
interface ps2_kbd_rx_if;
    import ps2_pkg::*;

    // No handshake: lclk is a level strobe; each rising edge (or reload while high) marks new kdata.
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] kdata;
    logic       lclk;
    logic       key_break;
    logic       key_ext;
    logic       err;
    ps2_state_t state;

    modport master (
        output ps2_clk, ps2_data,
        input  kdata, lclk, key_break, key_ext, err, state
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output kdata, lclk, key_break, key_ext, err, state
    );

endinterface

// File: rtl/ps2_sync_filter.sv
// Synchronises the PS/2 pins, debounces the clock and emits a one-cycle fall pulse.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data_s,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_dat_meta;
    logic          r_dat_sync;
    logic          r_filt;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_filt     <= 1'b1;
            r_fall     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
            r_fall     <= 1'b0;
            // Count consecutive samples that disagree with the filtered level.
            if (r_clk_sync == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_sync;
                r_fall <= r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_data_s = r_dat_sync;
    assign o_fall   = r_fall;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame FSM, parity check, watchdog, prefix decode, lclk strobe.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int STROBE_LEN     = 8
) (
    input  logic         clk,
    input  logic         reset,
    ps2_kbd_rx_if.slave  bus
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STROBE_LEN + 1);

    logic          w_data_s;
    logic          w_fall;
    ps2_state_t    r_state;
    logic [3:0]    r_bitcnt;
    logic [9:0]    r_shift;
    logic [WW-1:0] r_wd;
    logic          r_break_pend;
    logic          r_ext_pend;
    logic [7:0]    r_kdata;
    logic          r_lclk;
    logic          r_key_break;
    logic          r_key_ext;
    logic          r_err;
    logic [SW-1:0] r_stb_cnt;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_ps2_clk  (bus.ps2_clk),
        .i_ps2_data (bus.ps2_data),
        .o_data_s   (w_data_s),
        .o_fall     (w_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_wd         <= '0;
            r_break_pend <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_kdata      <= '0;
            r_lclk       <= 1'b0;
            r_key_break  <= 1'b0;
            r_key_ext    <= 1'b0;
            r_err        <= 1'b0;
            r_stb_cnt    <= '0;
        end else begin
            r_err <= 1'b0;
            if (r_stb_cnt != '0) begin
                r_stb_cnt <= r_stb_cnt - 1'b1;
                if (r_stb_cnt == SW'(1)) r_lclk <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !w_data_s) begin
                        r_bitcnt <= '0;
                        r_wd     <= '0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Bits enter at the top so D0 ends in bit 0 and stop in bit 9.
                    if (w_fall) begin
                        r_shift <= {w_data_s, r_shift[9:1]};
                        r_wd    <= '0;
                        if (r_bitcnt == 4'(FRAME_BITS - 2)) r_state  <= ST_CHECK;
                        else                                r_bitcnt <= r_bitcnt + 1'b1;
                    end else if (r_wd == WW'(TIMEOUT_CYCLES - 1)) begin
                        r_err        <= 1'b1;
                        r_break_pend <= 1'b0;
                        r_ext_pend   <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_state <= ST_IDLE;
                    if (!frame_ok(r_shift)) begin
                        r_err        <= 1'b1;
                        r_break_pend <= 1'b0;
                        r_ext_pend   <= 1'b0;
                    end else if (r_shift[7:0] == PS2_BREAK) begin
                        r_break_pend <= 1'b1;
                    end else if (r_shift[7:0] == PS2_EXT) begin
                        r_ext_pend <= 1'b1;
                    end else begin
                        r_kdata      <= r_shift[7:0];
                        r_key_break  <= r_break_pend;
                        r_key_ext    <= r_ext_pend;
                        r_break_pend <= 1'b0;
                        r_ext_pend   <= 1'b0;
                        r_stb_cnt    <= SW'(STROBE_LEN);
                        r_lclk       <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.kdata     = r_kdata;
    assign bus.lclk      = r_lclk;
    assign bus.key_break = r_key_break;
    assign bus.key_ext   = r_key_ext;
    assign bus.err       = r_err;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: table of frames, corner-case sequences, random frames vs model.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int TIMEOUT = 50000;
    localparam int STROBE  = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT), .STROBE_LEN(STROBE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int stop_fall_cyc = 0;
    int rises = 0;
    int err_seen = 0;
    int hi_len = 0;
    bit rst_seen = 1'b0;
    logic lclk_prev = 1'b0;
    logic [9:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every lclk rising edge must match the oldest expected code.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!reset) rst_seen = 1'b1;
        if (bus.err) err_seen++;
        if (bus.lclk && !lclk_prev) begin
            rises++;
            hi_len = 0;
            rst_seen = 1'b0;
            check("latency_window", 32'((cyc - stop_fall_cyc) >= 7 && (cyc - stop_fall_cyc) <= 9), 32'd1);
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe_code", {22'd0, bus.key_break, bus.key_ext, bus.kdata}, {22'd0, e});
            end
        end
        if (bus.lclk) hi_len++;
        if (!bus.lclk && lclk_prev && !rst_seen) check("strobe_len", 32'(hi_len), 32'(STROBE));
        lclk_prev = bus.lclk;
    end

    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            wait_cyc(half);
            if (i == FRAME_BITS - 1) stop_fall_cyc = cyc;
            bus.ps2_clk = 1'b0;
            wait_cyc(half);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        wait_cyc(half);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
        send_bits(mk_frame(b, bad_par, bad_stop), FRAME_BITS, half);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] kd, input logic brk, input logic ext);
        check({tag, "_kdata"}, 32'(bus.kdata), 32'(kd));
        check({tag, "_break"}, 32'(bus.key_break), 32'(brk));
        check({tag, "_ext"}, 32'(bus.key_ext), 32'(ext));
    endtask

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        int         strobes;
        logic [7:0] kd;
        bit         brk;
        bit         ext;
        int         errs;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int r0, e0, nexp, nerr, half, gap;
        bit m_brk, m_ext, bad;
        logic [7:0] b;

        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h1C, 1'b0, 1'b0, 0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b1, 1'b0, 0};
        vecs[3]  = '{8'h1D, 1'b0, 1'b0, 1, 8'h1D, 1'b0, 1'b0, 0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 0, 8'h1D, 1'b0, 1'b0, 0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h1D, 1'b0, 1'b0, 0};
        vecs[6]  = '{8'h75, 1'b0, 1'b0, 1, 8'h75, 1'b1, 1'b1, 0};
        vecs[7]  = '{8'h1C, 1'b1, 1'b0, 0, 8'h75, 1'b1, 1'b1, 1};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 0, 8'h75, 1'b1, 1'b1, 1};
        vecs[9]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h75, 1'b1, 1'b1, 0};
        vecs[10] = '{8'h1C, 1'b1, 1'b0, 0, 8'h75, 1'b1, 1'b1, 1};
        vecs[11] = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0};

        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b0;
        wait_cyc(5);
        check_outputs("reset", 8'h00, 1'b0, 1'b0);
        check("reset_lclk", 32'(bus.lclk), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_state", 32'(bus.state), 32'(ST_IDLE));
        reset = 1'b1;
        wait_cyc(10);

        for (int i = 0; i < 12; i++) begin
            r0 = rises;
            e0 = err_seen;
            if (vecs[i].strobes != 0) exp_q.push_back({vecs[i].brk, vecs[i].ext, vecs[i].kd});
            send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop, 12);
            wait_cyc(30);
            check($sformatf("vec%0d_strobes", i), 32'(rises - r0), 32'(vecs[i].strobes));
            check($sformatf("vec%0d_errs", i), 32'(err_seen - e0), 32'(vecs[i].errs));
            check_outputs($sformatf("vec%0d", i), vecs[i].kd, vecs[i].brk, vecs[i].ext);
        end

        // Short glitch on the clock while idle must be ignored.
        r0 = rises;
        e0 = err_seen;
        bus.ps2_clk = 1'b0;
        wait_cyc(2);
        bus.ps2_clk = 1'b1;
        wait_cyc(20);
        check("glitch_state", 32'(bus.state), 32'(ST_IDLE));
        check("glitch_err", 32'(err_seen - e0), 32'd0);
        check("glitch_strobes", 32'(rises - r0), 32'd0);

        // Start plus four data bits, then the clock stops.
        send_bits(mk_frame(8'h1B, 1'b0, 1'b0), 5, 12);
        check("partial_state", 32'(bus.state), 32'(ST_SHIFT));
        wait_cyc(TIMEOUT + 100);
        check("timeout_err", 32'(err_seen - e0), 32'd1);
        check("timeout_state", 32'(bus.state), 32'(ST_IDLE));
        check_outputs("timeout", 8'h1C, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h1B});
        send_frame(8'h1B, 1'b0, 1'b0, 12);
        wait_cyc(30);
        check_outputs("after_timeout", 8'h1B, 1'b0, 1'b0);

        // Reset while lclk is high.
        exp_q.push_back({2'b00, 8'h2A});
        send_bits(mk_frame(8'h2A, 1'b0, 1'b0), FRAME_BITS, 6);
        for (int k = 0; k < 30 && !bus.lclk; k++) wait_cyc(1);
        check("pre_reset_lclk", 32'(bus.lclk), 32'd1);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        check("strobe_reset_lclk", 32'(bus.lclk), 32'd0);
        check_outputs("strobe_reset", 8'h00, 1'b0, 1'b0);
        wait_cyc(20);

        // Reset in the middle of a frame, after a prefix was pending.
        exp_q.push_back({2'b00, 8'h34});
        send_frame(8'h34, 1'b0, 1'b0, 12);
        send_frame(8'hF0, 1'b0, 1'b0, 12);
        send_bits(mk_frame(8'h55, 1'b0, 1'b0), 5, 12);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        check_outputs("midframe_reset", 8'h00, 1'b0, 1'b0);
        check("midframe_reset_state", 32'(bus.state), 32'(ST_IDLE));
        wait_cyc(20);
        r0 = rises;
        exp_q.push_back({2'b00, 8'h23});
        send_frame(8'h23, 1'b0, 1'b0, 12);
        wait_cyc(30);
        check("after_reset_strobes", 32'(rises - r0), 32'd1);
        check_outputs("after_reset", 8'h23, 1'b0, 1'b0);

        // Random frames against a prefix/parity model.
        m_brk = 1'b0;
        m_ext = 1'b0;
        nexp = 0;
        nerr = 0;
        r0 = rises;
        e0 = err_seen;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = PS2_BREAK;
                2:       b = PS2_EXT;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bad = ($urandom_range(0, 9) == 0);
            half = $urandom_range(8, 16);
            gap = $urandom_range(20, 60);
            if (bad) begin
                nerr++;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end else if (b == PS2_BREAK) begin
                m_brk = 1'b1;
            end else if (b == PS2_EXT) begin
                m_ext = 1'b1;
            end else begin
                exp_q.push_back({m_brk, m_ext, b});
                nexp++;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
            if (bad && $urandom_range(0, 1) == 1) send_frame(b, 1'b0, 1'b1, half);
            else                                  send_frame(b, bad, 1'b0, half);
            wait_cyc(gap);
        end
        check("random_strobes", 32'(rises - r0), 32'(nexp));
        check("random_errs", 32'(err_seen - e0), 32'(nerr));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #(95000 * 10);
        failed++;
        $display("FAIL global_timeout: simulation did not complete, got no end, expected end");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end

endmodule
